// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: CPU (m0) has fixed priority, loader (m1) may lock bursts.
// Optional starvation guard for m1 is compiled in with `define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_stall,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state_q, state_d;
  logic   rd_pend_q, rd_pend_d;
  logic   rd_owner_q, rd_owner_d;
  logic   starve;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
    $error("dmem_arbiter: MAX_WAIT must be in 1..255");
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] WAIT_TH = 8'(MAX_WAIT);
  logic [7:0] wait_q, wait_d;

  assign starve = m1_req && (wait_q >= WAIT_TH);

  // Saturating count of cycles m1 has been left waiting
  always_comb begin
    wait_d = wait_q;
    if (m1_gnt)                        wait_d = 8'd0;
    else if (m1_req && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= 8'd0;
    else     wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      // A lock only holds while m1 keeps both req and lock; otherwise fall back to IDLE rules
      if (state_q == LOCKED && m1_req && m1_lock) m1_gnt = 1'b1;
      else if (m0_req && !starve)                 m0_gnt = 1'b1;
      else if (m1_req)                            m1_gnt = 1'b1;
    end
    if (m0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
    state_d    = (m1_gnt && m1_lock) ? LOCKED : IDLE;
    rd_pend_d  = mem_en && !mem_we;
    rd_owner_d = m1_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read data returns one cycle after the grant; reset in that cycle drops it
  assign m0_rvalid = rd_pend_q && !rd_owner_q && !rst;
  assign m1_rvalid = rd_pend_q &&  rd_owner_q && !rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign m0_stall  = m0_req && !m0_gnt && !rst;

endmodule
